// File: rtl/brq_pkg.sv
// ---------------------------------------------------------------------------
// brq_pkg
// Shared types for the execute-stage multiply/divide sequencer.
//   md_op_e          : requested MUL/DIV operation
//   md_sched_state_e : sequencer FSM state (IDLE, RUN, DRAIN, one spare)
//   md_op_is_div()   : 1 for DIV/REM, 0 for MULL/MULH
// ---------------------------------------------------------------------------
package brq_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_SCHED_IDLE  = 2'd0,
    MD_SCHED_RUN   = 2'd1,
    MD_SCHED_DRAIN = 2'd2,
    MD_SCHED_SPARE = 2'd3
  } md_sched_state_e;

  function automatic logic md_op_is_div(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/brq_md_rsp_buf.sv
// ---------------------------------------------------------------------------
// brq_md_rsp_buf
// One-entry 32-bit response register with valid/ready and flush.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : load push_data_i and mark the entry valid
//   push_data_i   : result to buffer
//   pop_i         : consumer ready; empties the entry
//   flush_i       : drop the entry
//   valid_o       : entry holds a result
//   data_o        : buffered result
// ---------------------------------------------------------------------------
module brq_md_rsp_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] data_o
);

  logic        valid_q;
  logic [31:0] data_q;

  // A push can only occur while the entry is empty (the sequencer refuses new
  // work until the buffer frees), so push taking priority over pop is safe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= push_data_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/brq_exu_md_sched.sv
// ---------------------------------------------------------------------------
// brq_exu_md_sched
// Sequencer for the slow multiply/divide datapath. Accepts one request at a
// time, latches its operands, drives the datapath enables/selects, owns the
// two 34-bit intermediate-value registers and buffers the result.
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        : request handshake from ID
//   req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i : request
//   kill_i                         : flush the in-flight operation
//   data_ind_timing_i              : CSR bit, sampled at accept
//   mult_en_o/div_en_o             : datapath dynamic enables
//   mult_sel_o/div_sel_o           : datapath static selects
//   operator_o ... data_ind_timing_o : latched request fields
//   imd_val_d_i/imd_val_we_i       : intermediate-value writes from datapath
//   imd_val_q_o                    : intermediate-value registers
//   md_valid_i/md_result_i         : datapath result
//   multdiv_ready_id_o             : lets the datapath leave LAST/FINISH
//   alu_md_sel_o                   : shared ALU adder belongs to multdiv
//   rsp_valid_o/rsp_ready_i/rsp_data_o : response handshake
//   busy_o                         : FSM not in IDLE
// ---------------------------------------------------------------------------
module brq_exu_md_sched
  import brq_pkg::*;
#(
  parameter logic DataIndTimingDefault = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  md_op_e      req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        kill_i,
  input  logic        data_ind_timing_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output md_op_e      operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        data_ind_timing_o,
  input  logic [33:0] imd_val_d_i [2],
  input  logic [1:0]  imd_val_we_i,
  output logic [33:0] imd_val_q_o [2],
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        multdiv_ready_id_o,
  output logic        alu_md_sel_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        busy_o
);

  md_sched_state_e state_q, state_d;
  md_op_e          operator_q;
  logic [1:0]      signed_mode_q;
  logic [31:0]     op_a_q, op_b_q;
  logic            data_ind_timing_q;
  logic [33:0]     imd_val_q [2];

  logic accept;
  logic rsp_push;
  logic md_active;
  logic is_div;
  logic rsp_flush;

  // The buffer frees in the same cycle its handshake completes, which lets a
  // new request be accepted back-to-back with the drain.
  assign req_ready_o = (state_q == MD_SCHED_IDLE) & (~rsp_valid_o | rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  // Kill in RUN wins over a same-cycle result; DRAIN ignores kill and only
  // waits for the datapath to report completion of the abandoned operation.
  always_comb begin
    state_d  = state_q;
    rsp_push = 1'b0;
    case (state_q)
      MD_SCHED_IDLE: begin
        if (accept) state_d = MD_SCHED_RUN;
      end
      MD_SCHED_RUN: begin
        if (kill_i) begin
          state_d = md_valid_i ? MD_SCHED_IDLE : MD_SCHED_DRAIN;
        end else if (md_valid_i) begin
          rsp_push = 1'b1;
          state_d  = MD_SCHED_IDLE;
        end
      end
      MD_SCHED_DRAIN: begin
        if (md_valid_i) state_d = MD_SCHED_IDLE;
      end
      default: state_d = MD_SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_SCHED_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      operator_q        <= MD_OP_MULL;
      signed_mode_q     <= 2'b00;
      op_a_q            <= 32'd0;
      op_b_q            <= 32'd0;
      data_ind_timing_q <= DataIndTimingDefault;
    end else if (accept) begin
      operator_q        <= req_operator_i;
      signed_mode_q     <= req_signed_mode_i;
      op_a_q            <= req_op_a_i;
      op_b_q            <= req_op_b_i;
      data_ind_timing_q <= data_ind_timing_i;
    end
  end

  // The datapath may write its scratch registers in any state, including
  // while it walks back to idle after a kill.
  for (genvar k = 0; k < 2; k++) begin : g_imd_val
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        imd_val_q[k] <= 34'd0;
      end else if (imd_val_we_i[k]) begin
        imd_val_q[k] <= imd_val_d_i[k];
      end
    end
    assign imd_val_q_o[k] = imd_val_q[k];
  end

  // Enables stay up in DRAIN so the datapath can finish the abandoned op and
  // return to its idle state before the next request is started.
  assign md_active          = (state_q == MD_SCHED_RUN) | (state_q == MD_SCHED_DRAIN);
  assign is_div             = md_op_is_div(operator_q);
  assign mult_en_o          = md_active & ~is_div;
  assign mult_sel_o         = md_active & ~is_div;
  assign div_en_o           = md_active & is_div;
  assign div_sel_o          = md_active & is_div;
  assign alu_md_sel_o       = md_active;
  assign multdiv_ready_id_o = md_active;
  assign busy_o             = (state_q != MD_SCHED_IDLE);

  assign operator_o        = operator_q;
  assign signed_mode_o     = signed_mode_q;
  assign op_a_o            = op_a_q;
  assign op_b_o            = op_b_q;
  assign data_ind_timing_o = data_ind_timing_q;

  // A kill seen while idle refers to the pending, not yet consumed, result.
  assign rsp_flush = kill_i & (state_q == MD_SCHED_IDLE);

  brq_md_rsp_buf u_rsp_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (rsp_push),
    .push_data_i (md_result_i),
    .pop_i       (rsp_ready_i),
    .flush_i     (rsp_flush),
    .valid_o     (rsp_valid_o),
    .data_o      (rsp_data_o)
  );

endmodule

// File: tb/tb_brq_exu_md_sched.sv
// ---------------------------------------------------------------------------
// tb_brq_exu_md_sched
// Self-checking bench for the multiply/divide sequencer. The bench plays the
// datapath: it raises md_valid_i after the latency the operation implies and
// supplies a result computed with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_brq_exu_md_sched;
  import brq_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  md_op_e      req_operator_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic        kill_i;
  logic        data_ind_timing_i;
  logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  md_op_e      operator_o;
  logic [1:0]  signed_mode_o;
  logic [31:0] op_a_o, op_b_o;
  logic        data_ind_timing_o;
  logic [33:0] imd_val_d_i [2];
  logic [1:0]  imd_val_we_i;
  logic [33:0] imd_val_q_o [2];
  logic        md_valid_i;
  logic [31:0] md_result_i;
  logic        multdiv_ready_id_o;
  logic        alu_md_sel_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        busy_o;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [33:0] imdExp [2];
  logic        pendingRsp;
  logic [31:0] pendingData;

  brq_exu_md_sched dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_operator_i     (req_operator_i),
    .req_signed_mode_i  (req_signed_mode_i),
    .req_op_a_i         (req_op_a_i),
    .req_op_b_i         (req_op_b_i),
    .kill_i             (kill_i),
    .data_ind_timing_i  (data_ind_timing_i),
    .mult_en_o          (mult_en_o),
    .div_en_o           (div_en_o),
    .mult_sel_o         (mult_sel_o),
    .div_sel_o          (div_sel_o),
    .operator_o         (operator_o),
    .signed_mode_o      (signed_mode_o),
    .op_a_o             (op_a_o),
    .op_b_o             (op_b_o),
    .data_ind_timing_o  (data_ind_timing_o),
    .imd_val_d_i        (imd_val_d_i),
    .imd_val_we_i       (imd_val_we_i),
    .imd_val_q_o        (imd_val_q_o),
    .md_valid_i         (md_valid_i),
    .md_result_i        (md_result_i),
    .multdiv_ready_id_o (multdiv_ready_id_o),
    .alu_md_sel_o       (alu_md_sel_o),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_data_o         (rsp_data_o),
    .busy_o             (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result of the operation, from 64-bit integer arithmetic.
  function automatic logic [31:0] refResult(input md_op_e op, input logic [1:0] sm,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
    sb = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
    case (op)
      MD_OP_MULL: begin r = sa * sb; return r[31:0]; end
      MD_OP_MULH: begin r = sa * sb; return r[63:32]; end
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        r = sa / sb;
        return r[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        r = sa % sb;
        return r[31:0];
      end
    endcase
  endfunction

  function automatic logic [8:0] obsStrobes();
    return {busy_o, alu_md_sel_o, mult_en_o, mult_sel_o, div_en_o, div_sel_o,
            multdiv_ready_id_o, req_ready_o, rsp_valid_o};
  endfunction

  // One clock: random scratch-register writes, then check them after the edge.
  task automatic tick();
    logic [1:0] we;
    we = 2'($urandom_range(0, 3));
    imd_val_we_i   = we;
    imd_val_d_i[0] = {2'($urandom), $urandom};
    imd_val_d_i[1] = {2'($urandom), $urandom};
    @(posedge clk_i);
    #1;
    if (rst_ni) begin
      for (int k = 0; k < 2; k++) if (we[k]) imdExp[k] = imd_val_d_i[k];
    end
    checkOutput("imd0", imd_val_q_o[0], imdExp[0]);
    checkOutput("imd1", imd_val_q_o[1], imdExp[1]);
  endtask

  // One operation: accept (draining any pending response), run the datapath
  // stub for the implied latency, then check the response and hold it.
  task automatic applyStimulus(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                               input logic [31:0] b, input logic dit, input logic [31:0] expRes,
                               input int killAt, input int rstAt, input int hold);
    int          lat;
    logic        killed;
    logic        d;
    logic [31:0] res;
    res = refResult(op, sm, a, b);
    d   = (op == MD_OP_DIV) || (op == MD_OP_REM);
    if (op == MD_OP_MULH)      lat = 32;
    else if (op == MD_OP_MULL) lat = dit ? 32 : $urandom_range(1, 31);
    else                       lat = (b == 32'd0 && !dit) ? 1 : 36;

    req_valid_i = 1'b1; req_operator_i = op; req_signed_mode_i = sm;
    req_op_a_i = a; req_op_b_i = b; data_ind_timing_i = dit;
    rsp_ready_i = 1'b1; kill_i = 1'b0; md_valid_i = 1'b0;
    #1;
    checkOutput("acceptReady", req_ready_o, 1'b1);
    if (pendingRsp) begin
      checkOutput("drainValid", rsp_valid_o, 1'b1);
      checkOutput("drainData", rsp_data_o, pendingData);
    end
    tick();
    pendingRsp = 1'b0;
    killed = 1'b0;

    for (int c = 1; c <= 1 + lat; c++) begin
      req_valid_i       = 1'($urandom_range(0, 1));
      req_operator_i    = md_op_e'($urandom_range(0, 3));
      req_signed_mode_i = 2'($urandom_range(0, 3));
      req_op_a_i        = $urandom;
      req_op_b_i        = $urandom;
      data_ind_timing_i = 1'($urandom_range(0, 1));
      rsp_ready_i       = 1'($urandom_range(0, 1));
      kill_i            = (c == killAt) || (killed && c == killAt + 1);
      md_valid_i        = (c == 1 + lat);
      md_result_i       = res;
      #1;
      checkOutput("runStrobes", obsStrobes(), {1'b1, 1'b1, ~d, ~d, d, d, 1'b1, 1'b0, 1'b0});
      if (c == 1) begin
        checkOutput("latchA", op_a_o, a);
        checkOutput("latchB", op_b_o, b);
        checkOutput("latchCtl", {operator_o, signed_mode_o, data_ind_timing_o}, {op, sm, dit});
      end
      if (c == rstAt) begin
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("rstStrobes", obsStrobes(), 9'b000000010);
        checkOutput("rstRsp", {rsp_valid_o, rsp_data_o}, 33'd0);
        checkOutput("rstLatch", {op_a_o, op_b_o, operator_o, signed_mode_o, data_ind_timing_o}, 69'd0);
        checkOutput("rstImd0", imd_val_q_o[0], 34'd0);
        checkOutput("rstImd1", imd_val_q_o[1], 34'd0);
        imdExp[0] = 34'd0; imdExp[1] = 34'd0;
        pendingRsp = 1'b0;
        kill_i = 1'b0; md_valid_i = 1'b0; req_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        return;
      end
      if (c == killAt) killed = 1'b1;
      tick();
    end

    req_valid_i = 1'b0; kill_i = 1'b0; md_valid_i = 1'b0; rsp_ready_i = 1'b0;
    #1;
    if (killed) begin
      checkOutput("killStrobes", obsStrobes(), 9'b000000010);
    end else begin
      checkOutput("doneStrobes", obsStrobes(), 9'b000000001);
      checkOutput("rspData", rsp_data_o, expRes);
      pendingRsp  = 1'b1;
      pendingData = expRes;
      for (int h = 0; h < hold; h++) begin
        tick();
        #1;
        checkOutput("holdStrobes", obsStrobes(), 9'b000000001);
        checkOutput("holdData", rsp_data_o, expRes);
      end
    end
  endtask

  // Kill while idle drops the pending response.
  task automatic idleKill();
    rsp_ready_i = 1'b0; req_valid_i = 1'b0; kill_i = 1'b1; md_valid_i = 1'b0;
    tick();
    kill_i = 1'b0;
    #1;
    checkOutput("idleKill", obsStrobes(), 9'b000000010);
    pendingRsp = 1'b0;
  endtask

  initial begin
    md_op_e      op;
    logic [1:0]  sm;
    logic [31:0] a, b;
    logic        dit;

    rst_ni = 1'b1;
    req_valid_i = 1'b0; req_operator_i = MD_OP_MULL; req_signed_mode_i = 2'b00;
    req_op_a_i = 32'd0; req_op_b_i = 32'd0; kill_i = 1'b0; data_ind_timing_i = 1'b0;
    imd_val_d_i[0] = 34'd0; imd_val_d_i[1] = 34'd0; imd_val_we_i = 2'b00;
    md_valid_i = 1'b0; md_result_i = 32'd0; rsp_ready_i = 1'b0;
    imdExp[0] = 34'd0; imdExp[1] = 34'd0;
    pendingRsp = 1'b0; pendingData = 32'd0;
    #1 rst_ni = 1'b0;
    tick();
    tick();
    checkOutput("resetStrobes", obsStrobes(), 9'b000000010);
    checkOutput("resetRsp", {rsp_valid_o, rsp_data_o}, 33'd0);
    checkOutput("resetLatch", {op_a_o, op_b_o, operator_o, signed_mode_o, data_ind_timing_o}, 69'd0);
    rst_ni = 1'b1;
    tick();

    applyStimulus(MD_OP_DIV,  2'b11, 32'd100, 32'd7, 1'b0, 32'd14, 0, 0, 0);
    applyStimulus(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 0, 0, 1);
    applyStimulus(MD_OP_DIV,  2'b11, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 0, 0, 0);
    applyStimulus(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 0, 0, 5);
    applyStimulus(MD_OP_MULL, 2'b11, 32'd3, 32'd4, 1'b1, 32'd12, 0, 0, 0);
    applyStimulus(MD_OP_MULL, 2'b11, 32'd3, 32'd4, 1'b0, 32'd12, 0, 0, 0);
    applyStimulus(MD_OP_DIV,  2'b11, 32'd100, 32'd7, 1'b0, 32'd14, 10, 0, 0);
    applyStimulus(MD_OP_MULL, 2'b11, 32'd2, 32'd3, 1'b0, 32'd6, 0, 0, 2);
    idleKill();
    applyStimulus(MD_OP_DIV,  2'b11, 32'd9, 32'd3, 1'b0, 32'd3, 37, 0, 0);
    applyStimulus(MD_OP_DIV,  2'b11, 32'd100, 32'd7, 1'b0, 32'd14, 0, 10, 0);
    applyStimulus(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b1, 32'd42, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op  = md_op_e'($urandom_range(0, 3));
      sm  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      dit = 1'($urandom_range(0, 1));
      applyStimulus(op, sm, a, b, dit, refResult(op, sm, a, b),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : 0,
                    0, $urandom_range(0, 3));
      if (pendingRsp && $urandom_range(0, 5) == 0) idleKill();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/brq_exu_md_sched.md
# brq_exu_md_sched

Sequencer for the slow multiply/divide datapath in the execute stage. It accepts one MUL/DIV request at a time from the ID stage and latches its operands. It drives the datapath's enable/select strobes and owns the two 34-bit intermediate-value registers the datapath borrows. It also tells the execute top when the shared ALU adder belongs to the multdiv path, and buffers the result in a one-entry response register with its own valid/ready handshake.

## Interface
- `DataIndTimingDefault`, 1'b0: reset value of the internal data-independent-timing control bit.
- `clk_i`  in  1  clock. One clock domain. Reset is asynchronous and active-low.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid_i` / `req_ready_o`  in/out  1  request handshake from ID.
- `req_operator_i`  in  md_op_e  requested operation: MULL/MULH/DIV/REM.
- `req_signed_mode_i`  in  2  [0] operand A signed, [1] operand B signed.
- `req_op_a_i`, `req_op_b_i`  in  32  request operands.
- `kill_i`  in  1  flush: drop the in-flight operation.
- `data_ind_timing_i`  in  1  CSR data-independent-timing bit, sampled at accept.
- `mult_en_o`, `div_en_o`  out  1  datapath dynamic enables.
- `mult_sel_o`, `div_sel_o`  out  1  datapath static selects.
- `operator_o`, `signed_mode_o`, `op_a_o`, `op_b_o`, `data_ind_timing_o`  out  latched copies of the request fields.
- `imd_val_d_i[2]`  in  34  datapath intermediate-value next values.
- `imd_val_we_i`  in  2  datapath intermediate-value write enables.
- `imd_val_q_o[2]`  out  34  intermediate-value registers.
- `md_valid_i`  in  1  datapath result valid.
- `md_result_i`  in  32  datapath result.
- `multdiv_ready_id_o`  out  1  permits the datapath to leave LAST/FINISH.
- `alu_md_sel_o`  out  1  ALU adder operands come from multdiv.
- `rsp_valid_o` / `rsp_ready_i`  out/in  1  response handshake.
- `rsp_data_o`  out  32  result.
- `busy_o`  out  1  any state other than IDLE.

## Operation
The block is a four-state FSM.
- IDLE: `req_ready_o`=1 when the response buffer is empty or is being drained this cycle. On `req_valid_i & req_ready_o`, latch operator, signed_mode, op_a, op_b and data_ind_timing, then go to RUN.
- RUN: assert `mult_en_o`/`mult_sel_o` for MULL/MULH, or `div_en_o`/`div_sel_o` for DIV/REM. Assert `alu_md_sel_o`=1 and `multdiv_ready_id_o`=1.
  - On `md_valid_i`, capture `md_result_i` into the response register, set `rsp_valid_o`, and go to IDLE.
  - On `kill_i`, go to DRAIN.
- DRAIN: enables and selects stay asserted and `multdiv_ready_id_o`=1, so the datapath walks back to its idle state. On `md_valid_i`, discard the result and go to IDLE. `kill_i` is ignored in this state.
- Response register: holds its value while `rsp_valid_o & ~rsp_ready_i`. It clears on `rsp_ready_i`. It is never overwritten while valid, because a new request cannot be accepted until the buffer frees.
- `imd_val_q_o[k]` is loaded from `imd_val_d_i[k]` whenever `imd_val_we_i[k]` is set, in any state.
- `kill_i` in IDLE drops a pending response: `rsp_valid_o` goes to 0 next cycle.
- A kill in the same cycle as `md_valid_i` in RUN takes priority: the result is discarded and the FSM goes to IDLE.

## Timing
- Reset values:
  - All outputs 0, except `req_ready_o`=1.
  - FSM in IDLE, response register 0, both `imd_val_q_o` registers 0.
  - Latched data_ind_timing = `DataIndTimingDefault`.
- Accept in cycle 0. The datapath sees its first enabled cycle in cycle 1 (datapath idle state).
- `md_valid_i` arrives in cycle 1+L. `rsp_valid_o` is registered and rises in cycle 2+L.
- L values:
  - MULH: L=32.
  - MULL with data-independent timing: L=32. MULL otherwise: L≤32.
  - DIV/REM: L=36.
  - DIV/REM by zero without data-independent timing: L=1.
- Throughput: a new request can be accepted in the same cycle the response handshake completes.
- Reset mid-operation: everything returns to reset values asynchronously. No response is produced.

## Structure
- Add `md_sched_state_e` (IDLE, RUN, DRAIN, plus one spare encoding) to `brq_pkg`, next to `md_op_e`.
- Add a helper in `brq_pkg` mapping `md_op_e` to is_div: DIV and REM map to 1.
- The response buffer is a natural sub-module `brq_md_rsp_buf`: a one-entry 32-bit valid/ready register with flush.
- Everything else stays flat in this module.

## Test plan
- DIV signed 100/7 accepted at cycle 0, `rsp_ready_i`=1 → `rsp_data_o`=14 with `rsp_valid_o` in cycle 38. `alu_md_sel_o` is high in cycles 1-37.
- REM signed -7 % 2 → 0xFFFFFFFF. DIV 5/0 with data_ind_timing=0 → 0xFFFFFFFF in cycle 3.
- MULH signed 0x80000000 × 0x80000000 → 0x40000000 in cycle 34. Hold `rsp_ready_i`=0 for 5 cycles → data stable, `req_ready_o`=0, then accepted and `req_ready_o`=1 the same cycle.
- MULL 3×4 with data_ind_timing=1 → 12 in cycle 34. Same operation with data_ind_timing=0 → 12 earlier.
- Assert `kill_i` in cycle 10 of a DIV → DRAIN, no `rsp_valid_o`. The next MULL 2×3 → 6, with no corruption from stale `imd_val_q_o`.
- Assert `rst_ni` low mid-DIV → all outputs at reset values immediately. A new request after reset completes correctly.
